// File: rtl/monitor_clk_pkg.sv
// Shared encodings for the monitor-driven target clock stepper: modes, FSM states,
// register map and CTRL bit positions.
package monitor_clk_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StBurst = 2'd2
    } state_e;

    localparam logic [1:0] ModeManual = 2'd0;
    localparam logic [1:0] ModeRun    = 2'd1;
    localparam logic [1:0] ModeBurst  = 2'd2;

    localparam logic [1:0] AddrCtrl     = 2'd0;
    localparam logic [1:0] AddrDiv      = 2'd1;
    localparam logic [1:0] AddrBurstLen = 2'd2;
    localparam logic [1:0] AddrCycles   = 2'd3;

    localparam int unsigned CtrlModeLsb  = 0;
    localparam int unsigned CtrlStartBit = 2;
    localparam int unsigned CtrlClearBit = 3;

endpackage

// File: rtl/monitor_sync2.sv
// Two-flop synchronizer for the asynchronous manual clock level.
module monitor_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/monitor_clk_stepper.sv
// Target CPU clock generator: manual pass-through, free-running divided clock, or a
// counted burst of rising edges, controlled over an Avalon-MM slave.
module monitor_clk_stepper
    import monitor_clk_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        manual_clk,
    output logic        tgt_clk,
    output logic        tgt_clk_en,
    output logic        busy
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      len_q, len_d;
    logic [31:0]      rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_q, tgt_d;
    logic             en_q;
    logic             hold_q, hold_d;
    logic             ref_q, ref_d;

    logic manual_sync;
    logic wr_en, ctrl_wr, start, clear;
    logic toggle, done, go_idle;

    monitor_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (manual_clk),
        .q_o     (manual_sync)
    );

    always_comb begin
        wr_en   = chipselect & ~write_n;
        ctrl_wr = wr_en && (address == AddrCtrl);
        mode_d  = mode_q;
        div_d   = div_q;
        len_d   = len_q;
        if (ctrl_wr) mode_d = writedata[CtrlModeLsb +: 2];
        if (wr_en && (address == AddrDiv)) div_d = writedata[DIV_W-1:0];
        if (wr_en && (address == AddrBurstLen)) len_d = writedata;
        start = ctrl_wr && writedata[CtrlStartBit] &&
                (writedata[CtrlModeLsb +: 2] == ModeBurst) &&
                (len_q != '0) && (state_q == StIdle);
        clear = ctrl_wr && writedata[CtrlClearBit];
        cnt_d = clear ? '0 : cnt_q + CNT_W'(en_q);
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        div_cnt_d = div_cnt_q;
        div_act_d = div_act_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
        ref_d     = ref_q;
        toggle    = (div_cnt_q == div_act_q);
        done      = 1'b0;
        go_idle   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // After leaving RUN/BURST, stay low until the manual level moves.
                if (hold_q && (manual_sync == ref_q)) begin
                    tgt_d = 1'b0;
                end else begin
                    hold_d = 1'b0;
                    tgt_d  = manual_sync;
                end
                if (mode_q == ModeRun) begin
                    state_d   = StRun;
                    div_cnt_d = '0;
                    div_act_d = div_q;
                end else if (start) begin
                    state_d   = StBurst;
                    rem_d     = len_q;
                    div_cnt_d = '0;
                    div_act_d = div_q;
                end
            end
            StRun, StBurst: begin
                done = (state_q == StRun) ? (mode_q != ModeRun)
                                          : ((mode_q != ModeBurst) || (rem_q == '0));
                if (done && !tgt_q) begin
                    go_idle = 1'b1;
                end else if (toggle) begin
                    div_cnt_d = '0;
                    div_act_d = div_q;
                    tgt_d     = ~tgt_q;
                    if (tgt_q) begin
                        go_idle = done;
                    end else if (state_q == StBurst) begin
                        rem_d = rem_q - 32'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
                if (go_idle) begin
                    state_d = StIdle;
                    tgt_d   = 1'b0;
                    hold_d  = 1'b1;
                    ref_d   = manual_sync;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            mode_q    <= ModeManual;
            div_q     <= '0;
            div_act_q <= '0;
            div_cnt_q <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            tgt_q     <= 1'b0;
            en_q      <= 1'b0;
            hold_q    <= 1'b0;
            ref_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            div_act_q <= div_act_d;
            div_cnt_q <= div_cnt_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            en_q      <= tgt_d & ~tgt_q;
            hold_q    <= hold_d;
            ref_q     <= ref_d;
        end
    end

    assign tgt_clk    = tgt_q;
    assign tgt_clk_en = en_q;
    assign busy       = (state_q == StRun) || (state_q == StBurst);

    always_comb begin
        readdata = '0;
        unique case (address)
            AddrCtrl:     readdata = {27'b0, busy, state_q, mode_q};
            AddrDiv:      readdata = 32'(div_q);
            AddrBurstLen: readdata = len_q;
            AddrCycles:   readdata = 32'(cnt_q);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_monitor_clk_stepper.sv
// Directed bench for monitor_clk_stepper: manual, run, burst, ignore, counter and reset cases.
`timescale 1ns / 1ps
module tb_monitor_clk_stepper;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        manual_clk;
    logic        tgt_clk;
    logic        tgt_clk_en;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int en_total = 0;

    monitor_clk_stepper #(
        .DIV_W (16),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .manual_clk (manual_clk),
        .tgt_clk    (tgt_clk),
        .tgt_clk_en (tgt_clk_en),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tgt_clk_en === 1'b1) en_total <= en_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_tgt(input logic v, output int n);
        n = 0;
        while (tgt_clk !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int n, n1, n2, base;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        manual_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tgt", {31'b0, tgt_clk}, 32'd0);
        chk("rst_en", {31'b0, tgt_clk_en}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        rd(2'd0, d); chk("rst_ctrl", d, 32'd0);
        rd(2'd1, d); chk("rst_div", d, 32'd0);
        rd(2'd2, d); chk("rst_len", d, 32'd0);
        rd(2'd3, d); chk("rst_cycles", d, 32'd0);

        // Manual pass-through, three-cycle latency each way
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            manual_clk = 1'b1;
            repeat (2) @(negedge clk);
            chk("man_rise_early", {31'b0, tgt_clk}, 32'd0);
            @(negedge clk);
            chk("man_rise", {31'b0, tgt_clk}, 32'd1);
            chk("man_en", {31'b0, tgt_clk_en}, 32'd1);
            @(negedge clk);
            chk("man_en_drop", {31'b0, tgt_clk_en}, 32'd0);
            manual_clk = 1'b0;
            repeat (2) @(negedge clk);
            chk("man_fall_early", {31'b0, tgt_clk}, 32'd1);
            @(negedge clk);
            chk("man_fall", {31'b0, tgt_clk}, 32'd0);
        end
        rd(2'd3, d); chk("man_cycles", d, 32'd3);

        // Free run with DIV=3
        wr(2'd1, 32'd3);
        rd(2'd1, d); chk("div_rb", d, 32'd3);
        wr(2'd0, 32'd1);
        wait_tgt(1'b1, n);
        chk("run_start_seen", {31'b0, n < 200}, 32'd1);
        chk("run_busy", {31'b0, busy}, 32'd1);
        rd(2'd0, d); chk("run_ctrl", d, 32'h15);
        wait_tgt(1'b0, n1);
        wait_tgt(1'b1, n2);
        chk("run_high", n1, 32'd4);
        chk("run_period", n1 + n2, 32'd8);
        wr(2'd0, 32'd0);
        @(negedge clk);
        chk("stop_high_held", {31'b0, tgt_clk}, 32'd1);
        chk("stop_busy_held", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("stop_fall", {31'b0, tgt_clk}, 32'd0);
        chk("stop_idle", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("stop_low", {31'b0, tgt_clk}, 32'd0);

        // Burst of 5 with DIV=1
        wr(2'd0, 32'h8);
        rd(2'd3, d); chk("clr", d, 32'd0);
        wr(2'd1, 32'd1);
        wr(2'd2, 32'd5);
        rd(2'd2, d); chk("len_rb", d, 32'd5);
        base = en_total;
        wr(2'd0, 32'h6);
        @(negedge clk);
        chk("burst_busy", {31'b0, busy}, 32'd1);
        rd(2'd0, d); chk("burst_ctrl", d, 32'h1A);
        repeat (40) @(negedge clk);
        chk("burst_edges", en_total - base, 32'd5);
        chk("burst_tgt_low", {31'b0, tgt_clk}, 32'd0);
        chk("burst_done", {31'b0, busy}, 32'd0);
        rd(2'd3, d); chk("burst_cycles", d, 32'd5);

        // Ignored starts
        wr(2'd2, 32'd0);
        base = en_total;
        wr(2'd0, 32'h6);
        repeat (20) @(negedge clk);
        chk("len0_edges", en_total - base, 32'd0);
        chk("len0_busy", {31'b0, busy}, 32'd0);
        wr(2'd2, 32'd3);
        base = en_total;
        wr(2'd0, 32'h4);
        repeat (20) @(negedge clk);
        chk("nomode_edges", en_total - base, 32'd0);
        base = en_total;
        wr(2'd0, 32'h6);
        repeat (5) @(negedge clk);
        wr(2'd0, 32'h6);
        repeat (40) @(negedge clk);
        chk("restart_edges", en_total - base, 32'd3);
        chk("restart_busy", {31'b0, busy}, 32'd0);

        // Counter wrap and clear-vs-increment
        wr(2'd0, 32'd0);
        @(negedge clk);
        force dut.cnt_q = '1;
        @(negedge clk);
        release dut.cnt_q;
        rd(2'd3, d); chk("preload", d, 32'hFFFF_FFFF);
        @(negedge clk);
        manual_clk = 1'b1;
        repeat (3) @(negedge clk);
        rd(2'd3, d); chk("wrap_before", d, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(2'd3, d); chk("wrap", d, 32'd0);
        manual_clk = 1'b0;
        repeat (4) @(negedge clk);
        manual_clk = 1'b1;
        repeat (3) @(negedge clk);
        chk("clr_en_hi", {31'b0, tgt_clk_en}, 32'd1);
        address    = 2'd0;
        writedata  = 32'h8;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(2'd3, d); chk("clr_wins", d, 32'd0);
        @(negedge clk);
        rd(2'd3, d); chk("clr_stays", d, 32'd0);
        manual_clk = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-burst while high
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd100);
        wr(2'd0, 32'h6);
        wait_tgt(1'b1, n);
        chk("rst_burst_high", {31'b0, n < 200}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tgt", {31'b0, tgt_clk}, 32'd0);
        chk("arst_en", {31'b0, tgt_clk_en}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        rd(2'd0, d); chk("arst_ctrl", d, 32'd0);
        rd(2'd1, d); chk("arst_div", d, 32'd0);
        rd(2'd2, d); chk("arst_len", d, 32'd0);
        rd(2'd3, d); chk("arst_cycles", d, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_tgt", {31'b0, tgt_clk}, 32'd0);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_clk_stepper.md
MONITOR_CLK_STEPPER -- requirements
Module: monitor_clk_stepper

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the half-period divider register.
REQ-002 SHALL have parameter CNT_W, default 32: width of the target rising-edge counter, at most 32.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-low (clk, reset_n).
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 address  in  2  Avalon-MM slave word address.
REQ-007 chipselect  in  1  Avalon-MM select.
REQ-008 write_n  in  1  Avalon-MM write strobe, active-low.
REQ-009 writedata  in  32  Avalon-MM write data.
REQ-010 readdata  out  32  Avalon-MM read data, zero-latency combinational mux.
REQ-011 manual_clk  in  1  level from the monitor PIO output port; asynchronous to clk.
REQ-012 tgt_clk  out  1  registered clock level driven to the target CPU.
REQ-013 tgt_clk_en  out  1  one-cycle pulse in the cycle tgt_clk goes 0->1.
REQ-014 busy  out  1  high while state is RUN or BURST.

Function
REQ-015 Registers: addr0 CTRL (W: [1:0] mode 0=MANUAL 1=RUN 2=BURST 3=treated as MANUAL; [2] burst start, self-clearing; [3] counter clear, self-clearing), addr1 DIV (R/W, DIV_W bits), addr2 BURST_LEN (R/W, 32 bits), addr3 CYCLES (RO).
REQ-016 Register write SHALL occur when chipselect=1 and write_n=0; writes to addr3 SHALL be ignored.
REQ-017 Read of addr0 SHALL return {27'b0, busy, state[1:0], mode[1:0]}; addr1/addr2 SHALL return the zero-extended stored value; addr3 SHALL return the counter.
REQ-018 States: IDLE, RUN, BURST; IDLE->RUN when mode=RUN; IDLE->BURST on burst start with mode=BURST and BURST_LEN!=0.
REQ-019 Burst start SHALL be ignored while busy, when mode!=BURST, or when BURST_LEN=0.
REQ-020 In MANUAL/IDLE, manual_clk SHALL pass through a 2-flop synchronizer and then drive tgt_clk; the latency from a manual_clk change to a tgt_clk change SHALL be 3 clk cycles.
REQ-021 In RUN/BURST, a divider counter SHALL count 0..DIV; at DIV it SHALL toggle tgt_clk and reload 0, giving a period of 2*(DIV+1) clk cycles; DIV=0 SHALL give a period of 2 cycles.
REQ-022 A DIV write during RUN SHALL take effect at the next divider reload.
REQ-023 BURST SHALL load remaining=BURST_LEN on entry, decrement on each tgt_clk rising edge, and at remaining=0 complete the high phase, drive tgt_clk low, and return to IDLE.
REQ-024 When mode leaves RUN, or leaves BURST mid-burst: if tgt_clk=1, SHALL finish the current high phase at its scheduled toggle and then go IDLE; if tgt_clk=0, SHALL go IDLE next cycle.
REQ-025 On entry to IDLE, tgt_clk SHALL hold low until the synchronized manual_clk next differs from the level it had at entry.
REQ-026 tgt_clk_en SHALL be derived from tgt_clk register transitions in every state; the counter SHALL increment on each tgt_clk_en.
REQ-027 The counter SHALL wrap from all-ones to 0; when clear and increment coincide, clear SHALL win (result 0).

Reset
REQ-028 On reset_n=0: state IDLE, mode MANUAL, DIV=0, BURST_LEN=0, remaining=0, counter=0, synchronizer flops=0, tgt_clk=0, tgt_clk_en=0, busy=0, readdata of addr0=0.
REQ-029 Reset mid-burst SHALL force tgt_clk low immediately (asynchronously); no completion of the high phase is required.

Structure
REQ-030 A shared package/include monitor_clk_pkg SHALL hold the mode encodings, state encodings, register addresses, and CTRL bit positions.
REQ-031 The synchronizer SHALL be the sub-module monitor_sync2 (2 flops, reset to 0); all other logic is flat.

Verification
REQ-032 Manual: toggle manual_clk 0->1->0 three times -> three tgt_clk pulses, each lagging manual_clk by 3 cycles; CYCLES=3.
REQ-033 Run: DIV=3, mode=RUN -> tgt_clk period 8 cycles, busy=1; set mode=MANUAL while tgt_clk=1 -> tgt_clk falls on schedule, then busy=0.
REQ-034 Burst: DIV=1, BURST_LEN=5, mode=BURST, start -> exactly 5 tgt_clk_en pulses, then tgt_clk=0, busy=0; CYCLES increments by 5.
REQ-035 Ignore cases: start with BURST_LEN=0 -> no edges; a second start during a burst -> total edges still equal BURST_LEN.
REQ-036 Counter: preload the counter to all-ones via force, then one edge -> CYCLES=0; clear coinciding with tgt_clk_en -> CYCLES=0.
REQ-037 Reset: assert reset_n mid-burst with tgt_clk=1 -> tgt_clk=0 and all registers take the REQ-028 values before the next clk edge.
